// File: rtl/reg_stack_ptr.sv
// Clocked stack-pointer register: load/inc/dec with wrap flag, bus drivers for SB/ADL/ADH,
// and a self-running post-reset sequence of dummy decrements.
module reg_stack_ptr #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      RESET_DECS  = 3,
    parameter logic [7:0]       STACK_PAGE  = 8'h01
) (
    input  logic             CLK,
    input  logic             RES_N,
    input  logic             SB_LOAD,
    input  logic             DEC,
    input  logic             INC,
    input  logic [WIDTH-1:0] SB_DATA,
    input  logic             SB_BUS_ENABLE,
    input  logic             ADL_BUS_ENABLE,
    output logic [WIDTH-1:0] SB_OUT,
    output logic [WIDTH-1:0] ADL_OUT,
    output logic [7:0]       ADH_OUT,
    output logic [WIDTH-1:0] SP,
    output logic             WRAP,
    output logic             BUSY
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    localparam state_t           RESET_STATE = (RESET_DECS > 0) ? ST_SEQ : ST_IDLE;
    localparam logic [7:0]       LAST_COUNT  = 8'(RESET_DECS - 1);
    localparam logic [WIDTH-1:0] ZERO        = '0;
    localparam logic [WIDTH-1:0] ALL_ONES    = '1;
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       count_r;
    logic [7:0]       count_s;
    logic [WIDTH-1:0] sp_r;
    logic [WIDTH-1:0] sp_s;
    logic             wrap_r;
    logic             wrap_s;

    // State, pointer, sequence counter and wrap flag registers.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_r <= RESET_STATE;
            count_r <= 8'd0;
            sp_r    <= RESET_VALUE;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            sp_r    <= sp_s;
            wrap_r  <= wrap_s;
        end
    end

    // Next-state and datapath: the reset sequence overrides every command.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        sp_s    = sp_r;
        wrap_s  = 1'b0;
        case (state_r)
            ST_SEQ: begin
                sp_s    = sp_r - ONE;
                wrap_s  = (sp_r == ZERO);
                count_s = count_r + 8'd1;
                if (count_r == LAST_COUNT) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SEQ;
                end
            end
            ST_IDLE: begin
                if (SB_LOAD) begin
                    sp_s = SB_DATA;
                end else if (DEC) begin
                    sp_s   = sp_r - ONE;
                    wrap_s = (sp_r == ZERO);
                end else if (INC) begin
                    sp_s   = sp_r + ONE;
                    wrap_s = (sp_r == ALL_ONES);
                end else begin
                    sp_s = sp_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Bus drivers stay combinational so an enable takes effect in the same cycle.
    assign SB_OUT  = SB_BUS_ENABLE  ? sp_r       : ZERO;
    assign ADL_OUT = ADL_BUS_ENABLE ? sp_r       : ZERO;
    assign ADH_OUT = ADL_BUS_ENABLE ? STACK_PAGE : 8'h00;
    assign SP      = sp_r;
    assign WRAP    = wrap_r;
    assign BUSY    = (state_r == ST_SEQ);

endmodule

// File: tb/tb_reg_stack_ptr.sv
// Scoreboard bench for reg_stack_ptr: default instance plus a 16-bit instance with no reset sequence.
module tb_reg_stack_ptr;

    typedef struct {
        logic [15:0] sp;
        logic        wrap;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res_n, sb_load, dec, inc, sb_en, adl_en;
    logic [7:0]  sb_data, sb_out, adl_out, adh_out, sp;
    logic        wrap, busy;

    logic        res2_n, sb_load2, dec2, inc2, sb_en2, adl_en2;
    logic [15:0] sb_data2, sb_out2, adl_out2, sp2;
    logic [7:0]  adh_out2;
    logic        wrap2, busy2;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    reg_stack_ptr dut (
        .CLK(clk), .RES_N(res_n), .SB_LOAD(sb_load), .DEC(dec), .INC(inc),
        .SB_DATA(sb_data), .SB_BUS_ENABLE(sb_en), .ADL_BUS_ENABLE(adl_en),
        .SB_OUT(sb_out), .ADL_OUT(adl_out), .ADH_OUT(adh_out), .SP(sp),
        .WRAP(wrap), .BUSY(busy)
    );

    reg_stack_ptr #(.WIDTH(16), .RESET_VALUE(16'h01FF), .RESET_DECS(0), .STACK_PAGE(8'h01)) dut2 (
        .CLK(clk), .RES_N(res2_n), .SB_LOAD(sb_load2), .DEC(dec2), .INC(inc2),
        .SB_DATA(sb_data2), .SB_BUS_ENABLE(sb_en2), .ADL_BUS_ENABLE(adl_en2),
        .SB_OUT(sb_out2), .ADL_OUT(adl_out2), .ADH_OUT(adh_out2), .SP(sp2),
        .WRAP(wrap2), .BUSY(busy2)
    );

    task automatic drive_cmd(input logic ld, input logic dc, input logic ic, input logic [7:0] d);
        sb_load = ld;
        dec     = dc;
        inc     = ic;
        sb_data = d;
    endtask

    task automatic test_reset();
        exp_t e;
        res_n = 1'b0;
        drive_cmd(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        total++;
        if (sp !== 8'h00 || busy !== 1'b1 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: sp=%h busy=%b wrap=%b required sp=00 busy=1 wrap=0", sp, busy, wrap);
        end
        exp_q.push_back('{16'h00FF, 1'b1, 1'b1});
        exp_q.push_back('{16'h00FE, 1'b0, 1'b1});
        exp_q.push_back('{16'h00FD, 1'b0, 1'b0});
        res_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({8'h00, sp} !== e.sp || wrap !== e.wrap || busy !== e.busy) begin
                bad++;
                $display("FAIL reset_seq: sp=%h wrap=%b busy=%b required sp=%h wrap=%b busy=%b",
                         sp, wrap, busy, e.sp[7:0], e.wrap, e.busy);
            end
        end
    endtask

    task automatic test_seq_ignore();
        exp_t e;
        @(negedge clk);
        res_n = 1'b0;
        drive_cmd(1'b1, 1'b1, 1'b1, 8'h42);
        @(negedge clk);
        exp_q.push_back('{16'h00FF, 1'b1, 1'b1});
        exp_q.push_back('{16'h00FE, 1'b0, 1'b1});
        exp_q.push_back('{16'h00FD, 1'b0, 1'b0});
        res_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({8'h00, sp} !== e.sp || wrap !== e.wrap || busy !== e.busy) begin
                bad++;
                $display("FAIL seq_ignore: sp=%h wrap=%b busy=%b required sp=%h wrap=%b busy=%b",
                         sp, wrap, busy, e.sp[7:0], e.wrap, e.busy);
            end
        end
        @(negedge clk);
        drive_cmd(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_idle_ops();
        exp_t       e;
        logic       ld[4], dc[4], ic[4], ew[4];
        logic [7:0] dt[4], esp[4];
        ld  = '{1'b1, 1'b0, 1'b0, 1'b0};
        dc  = '{1'b0, 1'b1, 1'b1, 1'b0};
        ic  = '{1'b0, 1'b0, 1'b0, 1'b1};
        dt  = '{8'h80, 8'h00, 8'h00, 8'h00};
        esp = '{8'h80, 8'h7F, 8'h7E, 8'h7F};
        ew  = '{1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_cmd(ld[i], dc[i], ic[i], dt[i]);
            exp_q.push_back('{{8'h00, esp[i]}, ew[i], 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({8'h00, sp} !== e.sp || wrap !== e.wrap || busy !== e.busy) begin
                bad++;
                $display("FAIL idle_ops step %0d: sp=%h wrap=%b busy=%b required sp=%h wrap=%b busy=%b",
                         i, sp, wrap, busy, e.sp[7:0], e.wrap, e.busy);
            end
        end
        @(negedge clk);
        drive_cmd(1'b0, 1'b0, 1'b0, 8'h00);
        sb_en = 1'b1; #1;
        total++;
        if (sb_out !== 8'h7F || adl_out !== 8'h00 || adh_out !== 8'h00) begin
            bad++;
            $display("FAIL sb_enable: sb=%h adl=%h adh=%h required sb=7f adl=00 adh=00", sb_out, adl_out, adh_out);
        end
        sb_en = 1'b0; adl_en = 1'b1; #1;
        total++;
        if (sb_out !== 8'h00 || adl_out !== 8'h7F || adh_out !== 8'h01) begin
            bad++;
            $display("FAIL adl_enable: sb=%h adl=%h adh=%h required sb=00 adl=7f adh=01", sb_out, adl_out, adh_out);
        end
        adl_en = 1'b0; #1;
        total++;
        if (sb_out !== 8'h00 || adl_out !== 8'h00 || adh_out !== 8'h00) begin
            bad++;
            $display("FAIL bus_disabled: sb=%h adl=%h adh=%h required all 00", sb_out, adl_out, adh_out);
        end
    endtask

    task automatic test_wrap();
        exp_t       e;
        logic       ld[4], dc[4], ic[4], ew[4];
        logic [7:0] esp[4];
        ld  = '{1'b1, 1'b0, 1'b0, 1'b0};
        dc  = '{1'b0, 1'b0, 1'b1, 1'b0};
        ic  = '{1'b0, 1'b1, 1'b0, 1'b0};
        esp = '{8'hFF, 8'h00, 8'hFF, 8'hFF};
        ew  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_cmd(ld[i], dc[i], ic[i], 8'hFF);
            exp_q.push_back('{{8'h00, esp[i]}, ew[i], 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({8'h00, sp} !== e.sp || wrap !== e.wrap || busy !== e.busy) begin
                bad++;
                $display("FAIL wrap step %0d: sp=%h wrap=%b busy=%b required sp=%h wrap=%b busy=%b",
                         i, sp, wrap, busy, e.sp[7:0], e.wrap, e.busy);
            end
        end
    endtask

    task automatic test_priority();
        exp_t       e;
        logic       ld[2], dc[2], ic[2];
        logic [7:0] esp[2];
        ld  = '{1'b1, 1'b0};
        dc  = '{1'b1, 1'b1};
        ic  = '{1'b1, 1'b1};
        esp = '{8'h10, 8'h0F};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_cmd(ld[i], dc[i], ic[i], 8'h10);
            exp_q.push_back('{{8'h00, esp[i]}, 1'b0, 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({8'h00, sp} !== e.sp || wrap !== e.wrap || busy !== e.busy) begin
                bad++;
                $display("FAIL priority step %0d: sp=%h wrap=%b busy=%b required sp=%h wrap=%b busy=%b",
                         i, sp, wrap, busy, e.sp[7:0], e.wrap, e.busy);
            end
        end
        @(negedge clk);
        drive_cmd(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_async_reset();
        exp_t e;
        #2 res_n = 1'b0;
        #1;
        total++;
        if (sp !== 8'h00 || busy !== 1'b1 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: sp=%h busy=%b wrap=%b required sp=00 busy=1 wrap=0", sp, busy, wrap);
        end
        @(negedge clk);
        exp_q.push_back('{16'h00FF, 1'b1, 1'b1});
        exp_q.push_back('{16'h00FE, 1'b0, 1'b1});
        exp_q.push_back('{16'h00FD, 1'b0, 1'b0});
        res_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if ({8'h00, sp} !== e.sp || wrap !== e.wrap || busy !== e.busy) begin
                bad++;
                $display("FAIL restart_seq: sp=%h wrap=%b busy=%b required sp=%h wrap=%b busy=%b",
                         sp, wrap, busy, e.sp[7:0], e.wrap, e.busy);
            end
        end
    endtask

    task automatic test_param();
        exp_t        e;
        logic        ld[6], ic[6], ew[6];
        logic [15:0] esp[6];
        @(negedge clk);
        total++;
        if (sp2 !== 16'h01FF || busy2 !== 1'b0 || wrap2 !== 1'b0) begin
            bad++;
            $display("FAIL param_reset: sp=%h busy=%b wrap=%b required sp=01ff busy=0 wrap=0", sp2, busy2, wrap2);
        end
        res2_n = 1'b1;
        ld  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ic  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        esp = '{16'h01FF, 16'h01FF, 16'h01FF, 16'hFFFF, 16'h0000, 16'h0000};
        ew  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            sb_load2 = ld[i];
            inc2     = ic[i];
            sb_data2 = 16'hFFFF;
            exp_q.push_back('{esp[i], ew[i], 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if (sp2 !== e.sp || wrap2 !== e.wrap || busy2 !== e.busy) begin
                bad++;
                $display("FAIL param step %0d: sp=%h wrap=%b busy=%b required sp=%h wrap=%b busy=%b",
                         i, sp2, wrap2, busy2, e.sp, e.wrap, e.busy);
            end
        end
        @(negedge clk);
        adl_en2 = 1'b1; #1;
        total++;
        if (adl_out2 !== 16'h0000 || adh_out2 !== 8'h01 || sb_out2 !== 16'h0000) begin
            bad++;
            $display("FAIL param_bus: adl=%h adh=%h sb=%h required adl=0000 adh=01 sb=0000", adl_out2, adh_out2, sb_out2);
        end
    endtask

    initial begin
        res_n  = 1'b0; sb_en  = 1'b0; adl_en  = 1'b0;
        drive_cmd(1'b0, 1'b0, 1'b0, 8'h00);
        res2_n = 1'b0; sb_en2 = 1'b0; adl_en2 = 1'b0;
        sb_load2 = 1'b0; dec2 = 1'b0; inc2 = 1'b0; sb_data2 = 16'h0000;
        test_reset();
        test_seq_ignore();
        test_idle_ops();
        test_wrap();
        test_priority();
        test_async_reset();
        test_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
